// File: rtl/fetch_pkg.sv
// Shared types and default sizing for the instruction fetch stage.
package fetch_pkg;

  localparam int DEF_ADDR_W  = 16;
  localparam int DEF_DATA_W  = 16;
  localparam int DEF_PC_INC  = 1;
  localparam int DEF_TIMEOUT = 15;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_DONE = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/fetch_timeout_ctr.sv
// Wait-cycle counter for the fetch REQ state; o_tc flags the cycle whose
// increment would reach TC_VAL.
module fetch_timeout_ctr
  import fetch_pkg::*;
#(
  parameter int unsigned TC_VAL = DEF_TIMEOUT
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clr,
  input  logic i_en,
  output logic o_tc
);

  localparam int unsigned CW = $clog2(TC_VAL + 1);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)
      r_cnt <= '0;
    else if (i_clr)
      r_cnt <= '0;
    else if (i_en)
      r_cnt <= r_cnt + CW'(1);
  end

  assign o_tc = (r_cnt == CW'(TC_VAL - 1));

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: latches PC, handshakes with instruction memory,
// fills the IR and drives the PC register update. Optional macro: FETCH_TIMEOUT_EN.
module instr_fetch_unit
  import fetch_pkg::*;
#(
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int PC_INC  = DEF_PC_INC,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  input  logic [ADDR_W-1:0] i_pc_in,
  input  logic [DATA_W-1:0] i_mem_rdata,
  input  logic              i_mem_ready,
  output logic              o_mem_req,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [DATA_W-1:0] o_ir_out,
  output logic [ADDR_W-1:0] o_pc_next,
  output logic              o_pc_en,
  output logic              o_fetch_done,
  output logic              o_busy,
  output logic              o_fetch_err
);

  fetch_state_e      r_state;
  fetch_state_e      w_state_nxt;
  logic [ADDR_W-1:0] r_addr_q;
  logic [DATA_W-1:0] r_ir;
  logic              w_accept;
  logic              w_capture;
  logic              w_abort;

`ifdef FETCH_TIMEOUT_EN
  logic w_tc;
  logic r_fetch_err;

  fetch_timeout_ctr #(
    .TC_VAL (TIMEOUT)
  ) u_timeout_ctr (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_clr (r_state != ST_REQ),
    .i_en  ((r_state == ST_REQ) && !i_mem_ready),
    .o_tc  (w_tc)
  );

  // mem_ready in the terminal cycle takes priority over the abort
  assign w_abort = (r_state == ST_REQ) && !i_mem_ready && w_tc;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)
      r_fetch_err <= 1'b0;
    else
      r_fetch_err <= w_abort;
  end

  assign o_fetch_err = r_fetch_err;
`else
  assign w_abort     = 1'b0;
  assign o_fetch_err = 1'b0;
`endif

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)
      r_state <= ST_IDLE;
    else
      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_capture   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (i_start) begin
          w_accept    = 1'b1;
          w_state_nxt = ST_REQ;
        end
      end
      ST_REQ: begin
        if (i_mem_ready) begin
          w_capture   = 1'b1;
          w_state_nxt = ST_DONE;
        end else if (w_abort) begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_DONE: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)
      r_addr_q <= '0;
    else if (w_accept)
      r_addr_q <= i_pc_in;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)
      r_ir <= '0;
    else if (w_capture)
      r_ir <= i_mem_rdata;
  end

  // Outputs decode from state so reset removes mem_req without a clock edge
  assign o_mem_req    = (r_state == ST_REQ);
  assign o_busy       = (r_state != ST_IDLE);
  assign o_pc_en      = (r_state == ST_DONE);
  assign o_fetch_done = (r_state == ST_DONE);
  assign o_mem_addr   = r_addr_q;
  assign o_ir_out     = r_ir;
  assign o_pc_next    = r_addr_q + ADDR_W'(PC_INC);

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Scoreboard bench for instr_fetch_unit: stimulus queues expected completions,
// a negedge monitor pops and compares them.
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] pc_in;
  logic [15:0] mem_rdata;
  logic        mem_ready;
  logic        mem_req;
  logic [15:0] mem_addr;
  logic [15:0] ir_out;
  logic [15:0] pc_next;
  logic        pc_en;
  logic        fetch_done;
  logic        busy;
  logic        fetch_err;

  int unsigned cyc = 0;
  int          n_tests = 0;
  int          n_fail  = 0;

  typedef struct {
    logic [15:0] ir;
    logic [15:0] pc_next;
    int unsigned cyc;
  } exp_t;

  exp_t        exp_q[$];
  int unsigned err_q[$];

  instr_fetch_unit dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_start      (start),
    .i_pc_in      (pc_in),
    .i_mem_rdata  (mem_rdata),
    .i_mem_ready  (mem_ready),
    .o_mem_req    (mem_req),
    .o_mem_addr   (mem_addr),
    .o_ir_out     (ir_out),
    .o_pc_next    (pc_next),
    .o_pc_en      (pc_en),
    .o_fetch_done (fetch_done),
    .o_busy       (busy),
    .o_fetch_err  (fetch_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every completion or abort must match the head of its queue
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && (fetch_done || pc_en)) begin
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_done: got done=%0b pc_en=%0b expected none (cycle %0d)",
                   fetch_done, pc_en, cyc);
        end else begin
          e = exp_q.pop_front();
          chk("done_flag", 32'(fetch_done), 32'd1);
          chk("done_pc_en", 32'(pc_en), 32'd1);
          chk("done_ir", 32'(ir_out), 32'(e.ir));
          chk("done_pc_next", 32'(pc_next), 32'(e.pc_next));
          chk("done_cycle", cyc, e.cyc);
        end
      end
      if (!rst && fetch_err) begin
        if (err_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_err: got fetch_err=1 expected 0 (cycle %0d)", cyc);
        end else begin
          chk("err_cycle", cyc, err_q.pop_front());
        end
      end
    end
  end

  task automatic drain();
    int k = 0;
    while ((exp_q.size() != 0 || err_q.size() != 0) && k < 60) begin
      @(negedge clk);
      k++;
    end
    if (exp_q.size() != 0 || err_q.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain_timeout: got %0d pending expected 0", exp_q.size() + err_q.size());
      exp_q.delete();
      err_q.delete();
    end
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned t0;
    rst = 1'b1; start = 1'b0; pc_in = '0; mem_rdata = '0; mem_ready = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_ir", 32'(ir_out), 32'h0000);
    chk("rst_pc_next", 32'(pc_next), 32'h0001);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_mem_addr", 32'(mem_addr), 32'h0000);
    chk("rst_err", 32'(fetch_err), 32'd0);

    // Zero-wait fetch; mem_ready high while idle must be ignored
    mem_ready = 1'b1;
    @(negedge clk);
    chk("idle_ready_busy", 32'(busy), 32'd0);
    mem_ready = 1'b0;
    pc_in = 16'h1234; start = 1'b1; t0 = cyc;
    exp_q.push_back('{ir: 16'hA5C3, pc_next: 16'h1235, cyc: t0 + 2});
    @(negedge clk);
    start = 1'b0; mem_ready = 1'b1; mem_rdata = 16'hA5C3;
    chk("zw_mem_req", 32'(mem_req), 32'd1);
    chk("zw_mem_addr", 32'(mem_addr), 32'h1234);
    chk("zw_busy", 32'(busy), 32'd1);
    @(negedge clk);
    mem_ready = 1'b0; mem_rdata = '0;
    drain();

    // Three wait states with pc_in changing mid-request
    pc_in = 16'h1234; start = 1'b1; t0 = cyc;
    exp_q.push_back('{ir: 16'h3C5A, pc_next: 16'h1235, cyc: t0 + 5});
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      start = 1'b0;
      if (i == 2) pc_in = 16'h5678;
      chk("ws_mem_addr", 32'(mem_addr), 32'h1234);
      chk("ws_mem_req", 32'(mem_req), 32'd1);
    end
    @(negedge clk);
    mem_ready = 1'b1; mem_rdata = 16'h3C5A;
    chk("ws_mem_addr_last", 32'(mem_addr), 32'h1234);
    @(negedge clk);
    mem_ready = 1'b0; mem_rdata = '0;
    chk("ws_done_addr", 32'(mem_addr), 32'h1234);
    drain();

    // Wrap at 0xFFFF with start held through the DONE cycle
    pc_in = 16'hFFFF; start = 1'b1; t0 = cyc;
    exp_q.push_back('{ir: 16'h0F0F, pc_next: 16'h0000, cyc: t0 + 3});
    @(negedge clk);
    @(negedge clk);
    mem_ready = 1'b1; mem_rdata = 16'h0F0F;
    @(negedge clk);
    mem_ready = 1'b0; mem_rdata = '0;
    @(negedge clk);
    start = 1'b0;
    chk("drop_busy", 32'(busy), 32'd0);
    chk("drop_mem_req", 32'(mem_req), 32'd0);
    @(negedge clk);
    chk("drop_busy2", 32'(busy), 32'd0);
    chk("wrap_ir", 32'(ir_out), 32'h0F0F);
    drain();

    // Asynchronous reset in the middle of REQ
    pc_in = 16'h4444; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("mid_mem_req_before", 32'(mem_req), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("mid_mem_req_async", 32'(mem_req), 32'd0);
    chk("mid_ir", 32'(ir_out), 32'h0000);
    chk("mid_busy", 32'(busy), 32'd0);
    chk("mid_pc_next", 32'(pc_next), 32'h0001);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("mid_after_busy", 32'(busy), 32'd0);
    chk("mid_after_ir", 32'(ir_out), 32'h0000);

`ifdef FETCH_TIMEOUT_EN
    // Abort after TIMEOUT wait cycles; garbage rdata must not reach IR
    pc_in = 16'h3000; start = 1'b1; t0 = cyc;
    err_q.push_back(t0 + 16);
    @(negedge clk);
    start = 1'b0; mem_rdata = 16'hDEAD;
    drain();
    chk("to_busy", 32'(busy), 32'd0);
    chk("to_ir", 32'(ir_out), 32'h0000);
    mem_rdata = '0;

    // mem_ready in the terminal cycle wins over abort
    pc_in = 16'h3100; start = 1'b1; t0 = cyc;
    exp_q.push_back('{ir: 16'hBEEF, pc_next: 16'h3101, cyc: t0 + 16});
    repeat (14) begin
      @(negedge clk);
      start = 1'b0;
    end
    @(negedge clk);
    mem_ready = 1'b1; mem_rdata = 16'hBEEF;
    @(negedge clk);
    mem_ready = 1'b0; mem_rdata = '0;
    drain();
`else
    // Without the timeout a long wait never aborts
    pc_in = 16'h2000; start = 1'b1; t0 = cyc;
    exp_q.push_back('{ir: 16'h6E6E, pc_next: 16'h2001, cyc: t0 + 22});
    repeat (20) begin
      @(negedge clk);
      start = 1'b0;
    end
    chk("long_busy", 32'(busy), 32'd1);
    chk("long_err", 32'(fetch_err), 32'd0);
    @(negedge clk);
    mem_ready = 1'b1; mem_rdata = 16'h6E6E;
    @(negedge clk);
    mem_ready = 1'b0; mem_rdata = '0;
    drain();
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/instr_fetch_unit.md
# instr_fetch_unit

Instruction fetch stage that sits directly downstream of the PC register in the multi-cycle RISC datapath. On a fetch request from the control unit it latches the current PC, performs a ready/request handshake with instruction memory, and captures the returned word into the instruction register. It also computes PC + increment and drives the PC register's load enable and data input, closing the PC update loop.

## Interface
Parameters:
- ADDR_W, 16, PC and instruction-memory address width.
- DATA_W, 16, instruction word width.
- PC_INC, 1, word increment added to the fetched PC (word-addressed memory).
- TIMEOUT, 15, maximum number of wait cycles in REQ before abort; used only when the timeout feature is compiled in.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  reset; asynchronous, active-high.
- start  in  1  fetch request from the control unit; sampled only in IDLE.
- pc_in  in  ADDR_W  current PC (PC register output).
- mem_rdata  in  DATA_W  instruction memory read data; valid when mem_ready=1.
- mem_ready  in  1  memory completes the read this cycle.
- mem_req  out  1  read request to memory.
- mem_addr  out  ADDR_W  read address; holds the latched PC.
- ir_out  out  DATA_W  instruction register.
- pc_next  out  ADDR_W  latched PC + PC_INC; connects to the PC register data input.
- pc_en  out  1  one-cycle load enable for the PC register.
- fetch_done  out  1  one-cycle pulse; ir_out holds the new instruction.
- busy  out  1  high in any state other than IDLE.
- fetch_err  out  1  one-cycle abort pulse; tied 0 when the timeout feature is compiled out.

## Operation
- States: IDLE, REQ, DONE.
- IDLE: if start=1, latch pc_in into addr_q and go to REQ. mem_ready in IDLE is ignored.
- REQ: mem_req=1 and mem_addr=addr_q. When mem_ready=1, capture mem_rdata into ir_out and go to DONE. Otherwise stay in REQ.
- DONE: fetch_done=1 and pc_en=1 for exactly this cycle. Then go unconditionally to IDLE.
- pc_next = addr_q + PC_INC, truncated to ADDR_W. It wraps modulo 2^ADDR_W (0xFFFF+1 → 0x0000). It is combinational from addr_q and valid whenever pc_en=1.
- addr_q is held constant from start acceptance to return to IDLE. Changes on pc_in during REQ/DONE have no effect.
- start while busy=1, including in the DONE cycle, is dropped. No queueing.
- ir_out changes only on a successful capture in REQ or on reset.
- Reset values: state IDLE; mem_req, pc_en, fetch_done, busy, fetch_err = 0; ir_out = 0; addr_q = 0, so mem_addr = 0 and pc_next = PC_INC.
- Reset asserted mid-fetch: mem_req drops immediately (asynchronously). No pc_en or fetch_done is produced for the aborted fetch.

## Timing
- start=1 in cycle N (IDLE) → mem_req=1 in cycle N+1.
- If mem_ready=1 in cycle N+1: ir_out is updated at the end of N+1, and fetch_done and pc_en are high in cycle N+2. Minimum latency is 2 cycles from start to fetch_done.
- Each cycle without mem_ready in REQ adds one cycle of latency.
- Earliest next accepted start is cycle N+3 (first IDLE cycle).
- All outputs are registered or decoded from state/registers. No combinational path from start or mem_ready to any output.

## Configuration
- FETCH_TIMEOUT_EN defined: a wait counter is cleared on entry to REQ and increments each REQ cycle with mem_ready=0.
  - When it reaches TIMEOUT with mem_ready still 0, go to IDLE and pulse fetch_err for 1 cycle.
  - On this abort: no pc_en, no fetch_done, ir_out unchanged.
  - mem_ready=1 in the same cycle the counter reaches TIMEOUT wins: normal capture.
- FETCH_TIMEOUT_EN undefined: no counter is instantiated, REQ waits indefinitely, and fetch_err is tied to 0.

## Structure
- Shared package fetch_pkg holds:
  - state enum (IDLE, REQ, DONE);
  - default width constants ADDR_W/DATA_W = 16;
  - PC_INC default.
- One sub-module, fetch_timeout_ctr: a cleared/enabled counter with a terminal-count output. It is instantiated only under FETCH_TIMEOUT_EN.

## Test plan
- Reset then idle: after rst deassert, mem_req=0, ir_out=0x0000, pc_next=0x0001, busy=0.
- Zero-wait fetch:
  - stimulus: pc_in=0x1234, start pulse, mem_ready=1 with mem_rdata=0xA5C3 in the first REQ cycle;
  - required: fetch_done and pc_en high 2 cycles after start, ir_out=0xA5C3, pc_next=0x1235.
- Wait states and pc_in change: mem_ready is delayed 3 cycles and pc_in changes to 0x5678 during REQ → mem_addr stays 0x1234 throughout and fetch_done comes 5 cycles after start.
- Wrap and dropped start:
  - stimulus: pc_in=0xFFFF, start held high for 4 cycles;
  - required: a single fetch, pc_next=0x0000, and the start seen in the DONE cycle ignored.
- Reset mid-REQ: rst asserted while mem_req=1 → mem_req falls without waiting for clk, no pc_en pulse, ir_out=0.
- With FETCH_TIMEOUT_EN, TIMEOUT=15 and mem_ready never asserted → fetch_err pulses 15 cycles after REQ entry, state returns to IDLE, and ir_out is unchanged.
